// File: rtl/noc_pkg.sv
// Shared router constants: port count, port-select width, port indices and
// the per-output arbiter state encoding.
package noc_pkg;

    localparam int unsigned NUM_PORTS      = 5;
    localparam int unsigned PORT_SEL_WIDTH = 3;

    localparam logic [PORT_SEL_WIDTH-1:0] PORT_LOCAL = 3'd0;
    localparam logic [PORT_SEL_WIDTH-1:0] PORT_NORTH = 3'd1;
    localparam logic [PORT_SEL_WIDTH-1:0] PORT_EAST  = 3'd2;
    localparam logic [PORT_SEL_WIDTH-1:0] PORT_SOUTH = 3'd3;
    localparam logic [PORT_SEL_WIDTH-1:0] PORT_WEST  = 3'd4;

    typedef enum logic {
        StIdle,
        StLocked
    } sa_state_e;

    // Round-robin successor over the five port indices.
    function automatic logic [PORT_SEL_WIDTH-1:0] rr_next(input logic [PORT_SEL_WIDTH-1:0] p);
        return (p == PORT_WEST) ? PORT_LOCAL : p + 3'd1;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the routing stage, input buffers, crossbar
// and the switch allocator.
interface switch_allocator_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0]                     req_valid;
    logic [NUM_PORTS-1:0][PORT_SEL_WIDTH-1:0] req_port;
    logic [NUM_PORTS-1:0]                     req_head;
    logic [NUM_PORTS-1:0]                     req_tail;
    logic [NUM_PORTS-1:0]                     out_ready;
    logic [NUM_PORTS-1:0]                     out_valid;
    logic [NUM_PORTS-1:0][PORT_SEL_WIDTH-1:0] xbar_sel;
    logic [NUM_PORTS-1:0]                     in_pop;
    logic                                     err_bad_port;

    modport master (
        output req_valid, req_port, req_head, req_tail, out_ready,
        input  out_valid, xbar_sel, in_pop, err_bad_port
    );

    modport slave (
        input  req_valid, req_port, req_head, req_tail, out_ready,
        output out_valid, xbar_sel, in_pop, err_bad_port
    );

endinterface

// File: rtl/sa_output_arbiter.sv
// Round-robin arbiter with packet lock for one output port: grants on a head,
// holds the owner until its tail transfers, then advances the pointer.
module sa_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned OutIdx = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req_valid,
    input  logic [NUM_PORTS-1:0][PORT_SEL_WIDTH-1:0] req_port,
    input  logic [NUM_PORTS-1:0]                     req_head,
    input  logic [NUM_PORTS-1:0]                     req_tail,
    input  logic                                     out_ready,
    output logic                                     out_valid,
    output logic [PORT_SEL_WIDTH-1:0]                xbar_sel,
    output logic [NUM_PORTS-1:0]                     pop
);

    localparam logic [PORT_SEL_WIDTH-1:0] OutCode = PORT_SEL_WIDTH'(OutIdx);

    sa_state_e                 state_q, state_d;
    logic [PORT_SEL_WIDTH-1:0] owner_q, owner_d;
    logic [PORT_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0]      cand;
    logic                      found;
    logic [PORT_SEL_WIDTH-1:0] pick;
    logic [PORT_SEL_WIDTH:0]   sum;
    logic [PORT_SEL_WIDTH-1:0] idx;
    logic                      xfer;

    // Invalid codes 5-7 never equal OutCode, so they drop out here.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand[i] = req_valid[i] && req_head[i] && (req_port[i] == OutCode);
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, rr_ptr_q} + 4'(k);
            if (sum >= 4'(NUM_PORTS)) begin
                sum = sum - 4'(NUM_PORTS);
            end
            idx = sum[PORT_SEL_WIDTH-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == StLocked) && req_valid[owner_q] && (req_port[owner_q] == OutCode);
        xfer      = out_valid && out_ready;
        xbar_sel  = owner_q;
        pop       = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pop[i] = xfer && (owner_q == PORT_SEL_WIDTH'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (xfer && req_tail[owner_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next(owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Five-output switch allocator: one locking round-robin arbiter per output,
// merged dequeue strobes, and a registered bad-port-code flag.
module switch_allocator
    import noc_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    switch_allocator_if.slave bus
);

    logic [NUM_PORTS-1:0]                     out_valid_w;
    logic [NUM_PORTS-1:0][PORT_SEL_WIDTH-1:0] xbar_sel_w;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]      pop_w;
    logic [NUM_PORTS-1:0]                     in_pop_w;
    logic                                     err_q, err_d;

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        sa_output_arbiter #(
            .OutIdx (j)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (bus.req_valid),
            .req_port  (bus.req_port),
            .req_head  (bus.req_head),
            .req_tail  (bus.req_tail),
            .out_ready (bus.out_ready[j]),
            .out_valid (out_valid_w[j]),
            .xbar_sel  (xbar_sel_w[j]),
            .pop       (pop_w[j])
        );
    end

    // An input requests one port, so at most one term per bit is ever set.
    always_comb begin
        in_pop_w = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            in_pop_w = in_pop_w | pop_w[j];
        end
    end

    always_comb begin
        err_d = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.req_valid[i] && bus.req_head[i] &&
                (bus.req_port[i] >= PORT_SEL_WIDTH'(NUM_PORTS))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.out_valid    = out_valid_w;
    assign bus.xbar_sel     = xbar_sel_w;
    assign bus.in_pop       = in_pop_w;
    assign bus.err_bad_port = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: single flit, contention, wrap-around,
// backpressure, parallel grants, bad codes and mid-packet reset.
module tb_switch_allocator;
    import noc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    switch_allocator_if ifc ();

    switch_allocator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        ifc.req_valid = '0;
        ifc.req_head  = '0;
        ifc.req_tail  = '0;
        ifc.req_port  = '0;
    endtask

    task automatic set_req(input int i, input logic [2:0] p, input logic h, input logic t);
        ifc.req_valid[i] = 1'b1;
        ifc.req_port[i]  = p;
        ifc.req_head[i]  = h;
        ifc.req_tail[i]  = t;
    endtask

    task automatic drop_req(input int i);
        ifc.req_valid[i] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int owners[3];
        int o;
        owners = '{0, 3, 4};
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_reqs();
        ifc.out_ready = '1;
        #12;
        check("rst_valid", 32'(ifc.out_valid), 32'h0);
        check("rst_pop", 32'(ifc.in_pop), 32'h0);
        check("rst_xbar", 32'(ifc.xbar_sel), 32'h0);
        check("rst_err", 32'(ifc.err_bad_port), 32'h0);
        rst_n = 1'b1;

        // Single-flit packet 1 -> 2, then rr_ptr[2]=2 favours input 2 over 1.
        next_cycle();
        set_req(1, 3'd2, 1'b1, 1'b1);
        settle();
        check("single_arb_valid", 32'(ifc.out_valid), 32'h0);
        check("single_arb_pop", 32'(ifc.in_pop), 32'h0);
        next_cycle();
        settle();
        check("single_valid", 32'(ifc.out_valid), 32'b00100);
        check("single_xbar", 32'(ifc.xbar_sel[2]), 32'd1);
        check("single_pop", 32'(ifc.in_pop), 32'b00010);
        next_cycle();
        set_req(2, 3'd2, 1'b1, 1'b1);
        settle();
        check("single_bubble", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("rr2_valid", 32'(ifc.out_valid), 32'b00100);
        check("rr2_xbar", 32'(ifc.xbar_sel[2]), 32'd2);
        check("rr2_pop", 32'(ifc.in_pop), 32'b00100);
        next_cycle();
        drop_req(2);
        settle();
        check("rr2_idle_valid", 32'(ifc.out_valid), 32'h0);
        check("rr2_idle_xbar", 32'(ifc.xbar_sel[2]), 32'd2);
        next_cycle();
        settle();
        check("rr2_next_xbar", 32'(ifc.xbar_sel[2]), 32'd1);
        check("rr2_next_pop", 32'(ifc.in_pop), 32'b00010);
        next_cycle();
        clear_reqs();
        settle();
        check("single_done", 32'(ifc.out_valid), 32'h0);

        // Contention on port 1 from reset: 3-flit packets granted 0, 3, 4.
        do_reset();
        next_cycle();
        set_req(0, 3'd1, 1'b1, 1'b0);
        set_req(3, 3'd1, 1'b1, 1'b0);
        set_req(4, 3'd1, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            o = owners[p];
            settle();
            check("cont_arb_valid", 32'(ifc.out_valid), 32'h0);
            check("cont_arb_pop", 32'(ifc.in_pop), 32'h0);
            for (int f = 0; f < 3; f++) begin
                next_cycle();
                set_req(o, 3'd1, f == 0, f == 2);
                settle();
                check("cont_valid", 32'(ifc.out_valid), 32'b00010);
                check("cont_xbar", 32'(ifc.xbar_sel[1]), 32'(o));
                check("cont_pop", 32'(ifc.in_pop), 32'd1 << o);
            end
            next_cycle();
            drop_req(o);
        end
        clear_reqs();

        // Wrap-around: owner 3 leaves rr_ptr[0]=4, so 4 beats 0.
        next_cycle();
        set_req(3, 3'd0, 1'b1, 1'b1);
        settle();
        check("wrap_arb", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("wrap_valid3", 32'(ifc.out_valid), 32'b00001);
        check("wrap_xbar3", 32'(ifc.xbar_sel[0]), 32'd3);
        check("wrap_pop3", 32'(ifc.in_pop), 32'b01000);
        next_cycle();
        drop_req(3);
        set_req(4, 3'd0, 1'b1, 1'b1);
        set_req(0, 3'd0, 1'b1, 1'b1);
        settle();
        check("wrap_arb2", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("wrap_xbar4", 32'(ifc.xbar_sel[0]), 32'd4);
        check("wrap_pop4", 32'(ifc.in_pop), 32'b10000);
        next_cycle();
        drop_req(4);
        settle();
        check("wrap_bubble", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("wrap_xbar0", 32'(ifc.xbar_sel[0]), 32'd0);
        check("wrap_pop0", 32'(ifc.in_pop), 32'b00001);
        next_cycle();
        clear_reqs();

        // Backpressure on port 3 mid-packet; input 0 waits behind the lock.
        next_cycle();
        set_req(1, 3'd3, 1'b1, 1'b0);
        settle();
        check("bp_arb", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("bp_head_valid", 32'(ifc.out_valid), 32'b01000);
        check("bp_head_xbar", 32'(ifc.xbar_sel[3]), 32'd1);
        check("bp_head_pop", 32'(ifc.in_pop), 32'b00010);
        next_cycle();
        set_req(1, 3'd3, 1'b0, 1'b0);
        set_req(0, 3'd3, 1'b1, 1'b1);
        ifc.out_ready[3] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            check("bp_stall_valid", 32'(ifc.out_valid), 32'b01000);
            check("bp_stall_pop", 32'(ifc.in_pop), 32'h0);
            check("bp_stall_xbar", 32'(ifc.xbar_sel[3]), 32'd1);
            next_cycle();
        end
        ifc.out_ready[3] = 1'b1;
        settle();
        check("bp_body_pop", 32'(ifc.in_pop), 32'b00010);
        next_cycle();
        set_req(1, 3'd3, 1'b0, 1'b1);
        settle();
        check("bp_tail_pop", 32'(ifc.in_pop), 32'b00010);
        next_cycle();
        drop_req(1);
        settle();
        check("bp_bubble", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("bp_next_valid", 32'(ifc.out_valid), 32'b01000);
        check("bp_next_xbar", 32'(ifc.xbar_sel[3]), 32'd0);
        check("bp_next_pop", 32'(ifc.in_pop), 32'b00001);
        next_cycle();
        clear_reqs();

        // Parallel grants: 0->2, 1->3, 2->0.
        next_cycle();
        set_req(0, 3'd2, 1'b1, 1'b1);
        set_req(1, 3'd3, 1'b1, 1'b1);
        set_req(2, 3'd0, 1'b1, 1'b1);
        settle();
        check("par_arb", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("par_valid", 32'(ifc.out_valid), 32'b01101);
        check("par_pop", 32'(ifc.in_pop), 32'b00111);
        check("par_xbar2", 32'(ifc.xbar_sel[2]), 32'd0);
        check("par_xbar3", 32'(ifc.xbar_sel[3]), 32'd1);
        check("par_xbar0", 32'(ifc.xbar_sel[0]), 32'd2);
        next_cycle();
        clear_reqs();
        settle();
        check("par_done", 32'(ifc.out_valid), 32'h0);

        // Bad code on input 2 plus a stray body flit on input 4 to idle port 0.
        next_cycle();
        set_req(2, 3'd6, 1'b1, 1'b1);
        set_req(4, 3'd0, 1'b0, 1'b0);
        settle();
        check("bad_err0", 32'(ifc.err_bad_port), 32'h0);
        check("bad_valid0", 32'(ifc.out_valid), 32'h0);
        next_cycle();
        settle();
        check("bad_err1", 32'(ifc.err_bad_port), 32'h1);
        check("bad_valid1", 32'(ifc.out_valid), 32'h0);
        check("bad_pop1", 32'(ifc.in_pop), 32'h0);
        next_cycle();
        drop_req(2);
        settle();
        check("bad_err2", 32'(ifc.err_bad_port), 32'h1);
        check("body_ignored", 32'(ifc.in_pop), 32'h0);
        next_cycle();
        settle();
        check("bad_err3", 32'(ifc.err_bad_port), 32'h0);
        next_cycle();
        clear_reqs();

        // Reset mid-packet drops the lock at once.
        next_cycle();
        set_req(0, 3'd1, 1'b1, 1'b0);
        settle();
        next_cycle();
        settle();
        check("mid_head_valid", 32'(ifc.out_valid), 32'b00010);
        check("mid_head_pop", 32'(ifc.in_pop), 32'b00001);
        next_cycle();
        set_req(0, 3'd1, 1'b0, 1'b0);
        settle();
        check("mid_body_valid", 32'(ifc.out_valid), 32'b00010);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ifc.out_valid), 32'h0);
        check("mid_rst_pop", 32'(ifc.in_pop), 32'h0);
        check("mid_rst_xbar", 32'(ifc.xbar_sel), 32'h0);
        #1;
        rst_n = 1'b1;
        next_cycle();
        settle();
        check("mid_after_valid", 32'(ifc.out_valid), 32'h0);
        check("mid_after_pop", 32'(ifc.in_pop), 32'h0);
        next_cycle();
        clear_reqs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator: consumes the 3-bit output-port selections from the routing stage for all five input ports and grants each output port to one input for the duration of a packet (head to tail). It drives the crossbar select lines, the per-output valid, and the input-buffer dequeue strobes. One round-robin arbiter with lock per output port, so up to five packets cross the router in parallel.

## Interface
- NUM_PORTS, 5, input/output port count; fixed at 5. Index 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
- PORT_SEL_WIDTH, 3, width of a port selection; codes 5–7 are invalid.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  [NUM_PORTS-1:0]  input i has a flit at the buffer head.
- req_port  in  [PORT_SEL_WIDTH-1:0] x NUM_PORTS  requested output for input i's head flit, from the routing stage.
- req_head  in  [NUM_PORTS-1:0]  head-flit flag of input i's head flit.
- req_tail  in  [NUM_PORTS-1:0]  tail-flit flag; a single-flit packet has head and tail both set.
- out_ready  in  [NUM_PORTS-1:0]  downstream of output j accepts a flit this cycle.
- out_valid  out  [NUM_PORTS-1:0]  output j carries a valid flit this cycle.
- xbar_sel  out  [PORT_SEL_WIDTH-1:0] x NUM_PORTS  input index driving output j.
- in_pop  out  [NUM_PORTS-1:0]  dequeue input i's head flit at this edge.
- err_bad_port  out  1  registered one-cycle pulse: a valid head requested code 5–7 in the previous cycle.

## Operation
- Per-output FSM with states IDLE and LOCKED, plus owner[j] (3 bits) and rr_ptr[j] (3 bits).
- A candidate for output j is input i with req_valid[i], req_head[i], and req_port[i]==j.
- IDLE: if any candidate exists, pick the first one searching i = rr_ptr[j], rr_ptr[j]+1, … mod 5. Set owner[j] to that input and go to LOCKED. No flit moves in the arbitration cycle.
- LOCKED: out_valid[j] = req_valid[owner] and req_port[owner]==j. xbar_sel[j] = owner. in_pop[owner] = out_valid[j] and out_ready[j].
- LOCKED transfer with req_tail[owner] set: go to IDLE and set rr_ptr[j] = owner+1 mod 5 (4 wraps to 0).
- LOCKED with out_ready low or req_valid[owner] low: hold state and owner; the transfer stalls without limit.
- Inputs that are not heads or request an invalid code are never candidates. Non-head flits that reach an IDLE output are ignored (protocol violation; no pop).
- Each input selects one port, so it owns at most one output. in_pop is the OR across outputs, with at most one term set per input.
- IDLE outputs drive out_valid=0 and xbar_sel=owner (last value).

## Timing
- Reset (asynchronous assert, synchronous release): all states IDLE, owner 0, rr_ptr 0, err_bad_port 0. Outputs out_valid=0, in_pop=0, xbar_sel=0.
- Grant latency is 1 cycle: a head presented in cycle t transfers at the earliest in t+1. A packet of N flits with constant ready occupies an output for N+1 cycles.
- One bubble cycle after each tail, because the next arbitration happens in IDLE.
- A tail transfer and a new head request for the same output in the same cycle: the new head is arbitrated in the following cycle using the updated rr_ptr.
- Reset asserted mid-packet clears every lock immediately. Upstream buffers share rst_n and are flushed as well.
- out_valid, xbar_sel and in_pop are combinational from state and current-cycle inputs, with no combinational path from out_ready to out_valid.

## Structure
- Shared package noc_pkg holds NUM_PORTS, PORT_SEL_WIDTH, the port-index constants PORT_LOCAL..PORT_WEST, and the FSM state enum.
- Sub-module sa_output_arbiter (one instance per output) holds the FSM, owner, rr_ptr and the round-robin search. The top instantiates 5 copies, ORs the in_pop contributions, and generates err_bad_port.

## Test plan
- Single-flit packet: input 1 head+tail to port 2 with ready=1 in cycle 0. Required: cycle 1 has out_valid[2]=1, xbar_sel[2]=1, in_pop[1]=1; cycle 2 output 2 is IDLE; rr_ptr[2]=2.
- Contention: inputs 0, 3, 4 send heads to port 1 from reset. Required: grants in order 0, 3, 4. Each 3-flit packet takes 4 cycles, and no flits from different packets interleave.
- Wrap-around: with rr_ptr[0]=4 set by a prior owner 3, inputs 4 and 0 contend. Required: 4 is granted, then rr_ptr becomes 0 and input 0 is granted next.
- Backpressure: out_ready[3]=0 for 5 cycles mid-packet. Required: out_valid[3] stays 1, in_pop stays 0, the lock is held, and the remaining flits transfer once ready=1.
- Parallelism: inputs 0→2, 1→3 and 2→0 at the same time. Required: all three outputs lock in the same cycle and transfer concurrently.
- Invalid/reset: input 2 head with req_port=6. Required: never granted, err_bad_port pulses the next cycle. rst_n low mid-packet: out_valid and in_pop drop to 0 immediately.
